// File: rtl/adder_acc64_pkg.sv
// ============================================================================
// adder_pkg : shared widths and FSM state encoding for adder_acc64
// Revision  : 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/adder_acc64_if.sv
// ============================================================================
// adder_acc64_if : term input / result output handshake bundle
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface adder_acc64_if;
    import adder_pkg::*;

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_co;
    logic [CNT_W-1:0]  out_cnt;
    logic              busy;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_co, out_cnt, busy
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_co, out_cnt, busy
    );

endinterface

`default_nettype wire

// File: rtl/adder_acc64_sparse_adder.sv
// ============================================================================
// sparse_adder64 : 64-bit adder, Kogge-Stone carry tree on 4-bit blocks with
//                  carry-select sums inside each block
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sparse_adder64
    import adder_pkg::*;
(
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    output logic      [DATA_W-1:0] sum,
    output logic                   co
);

    localparam int BLK_W  = 4;
    localparam int N_BLK  = DATA_W / BLK_W;
    localparam int LEVELS = 4;

    logic [DATA_W-1:0]           gen;
    logic [DATA_W-1:0]           prop;
    logic [LEVELS:0][N_BLK-1:0]  bg;
    logic [LEVELS:0][N_BLK-1:0]  bp;
    logic [N_BLK-1:0]            blk_cin;
    logic [DATA_W-1:0]           sum0;
    logic [DATA_W-1:0]           sum1;
    logic                        c0;
    logic                        c1;

    always_comb begin
        gen     = a & b;
        prop    = a ^ b;
        bg      = '0;
        bp      = '0;
        blk_cin = '0;
        sum0    = '0;
        sum1    = '0;
        c0      = 1'b0;
        c1      = 1'b1;

        for (int k = 0; k < N_BLK; k++) begin
            bg[0][k] = gen[4*k+3]
                     | (prop[4*k+3] & gen[4*k+2])
                     | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                     | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
            bp[0][k] = &prop[4*k +: BLK_W];
        end

        // Prefix over blocks: after LEVELS steps bg[LEVELS][k] is the carry out of blocks 0..k
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = 0; k < N_BLK; k++) begin
                if (k >= (1 << l)) begin
                    bg[l+1][k] = bg[l][k] | (bp[l][k] & bg[l][k-(1<<l)]);
                    bp[l+1][k] = bp[l][k] & bp[l][k-(1<<l)];
                end else begin
                    bg[l+1][k] = bg[l][k];
                    bp[l+1][k] = bp[l][k];
                end
            end
        end

        for (int k = 1; k < N_BLK; k++) begin
            blk_cin[k] = bg[LEVELS][k-1];
        end

        for (int k = 0; k < N_BLK; k++) begin
            c0 = 1'b0;
            c1 = 1'b1;
            for (int j = 0; j < BLK_W; j++) begin
                sum0[4*k+j] = prop[4*k+j] ^ c0;
                sum1[4*k+j] = prop[4*k+j] ^ c1;
                c0          = gen[4*k+j] | (prop[4*k+j] & c0);
                c1          = gen[4*k+j] | (prop[4*k+j] & c1);
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < N_BLK; k++) begin
            sum[4*k +: BLK_W] = blk_cin[k] ? sum1[4*k +: BLK_W] : sum0[4*k +: BLK_W];
        end
    end

    assign co = bg[LEVELS][N_BLK-1];

endmodule

`default_nettype wire

// File: rtl/adder_acc64.sv
// ============================================================================
// adder_acc64 : frames of LEN 64-bit terms summed modulo 2^64 with sticky carry
// Revision    : 1.0
// ============================================================================
`default_nettype none

module adder_acc64
    import adder_pkg::*;
#(
    parameter int LEN = 8
)
(
    input  wire logic   clk,
    input  wire logic   rst,
    adder_acc64_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] add_sum;
    logic              add_co;
    logic              sticky_co;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              clear;

    sparse_adder64 u_adder (
        .a   (acc),
        .b   (bus.in_data),
        .sum (add_sum),
        .co  (add_co)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = ACCUM;
                    clear     = 1'b1;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (cnt == LAST_CNT) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // start only counts here together with the result handoff
                if (bus.out_ready) begin
                    if (bus.start) begin
                        state_nxt = ACCUM;
                        clear     = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            sticky_co <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                acc       <= '0;
                sticky_co <= 1'b0;
                cnt       <= '0;
            end else if (accept) begin
                acc       <= add_sum;
                sticky_co <= sticky_co | add_co;
                cnt       <= cnt + 8'd1;
            end
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_sum   = acc;
    assign bus.out_co    = sticky_co;
    assign bus.out_cnt   = cnt;

endmodule

`default_nettype wire

// File: tb/tb_adder_acc64.sv
// ============================================================================
// tb_adder_acc64 : directed checks of adder_acc64 with LEN = 4, 2 and 1
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_adder_acc64;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    adder_acc64_if b4 ();
    adder_acc64_if b2 ();
    adder_acc64_if b1 ();

    adder_acc64 #(.LEN(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    adder_acc64 #(.LEN(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    adder_acc64 #(.LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed4(input logic v, input logic [63:0] d);
        b4.in_valid = v;
        b4.in_data  = d;
        tick();
    endtask

    logic [63:0] va [6];
    logic [63:0] vb [6];
    logic [63:0] vs [6];
    logic        vc [6];
    logic        pat [7];
    int          model_cnt;

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst   = 1'b1;
        {b4.start, b4.in_valid, b4.out_ready} = 3'b000; b4.in_data = '0;
        {b2.start, b2.in_valid, b2.out_ready} = 3'b000; b2.in_data = '0;
        {b1.start, b1.in_valid, b1.out_ready} = 3'b000; b1.in_data = '0;

        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'h2;                   vs[0] = 64'h1;                   vc[0] = 1'b1;
        va[1] = 64'h0123_4567_89AB_CDEF; vb[1] = 64'hFEDC_BA98_7654_3210; vs[1] = 64'hFFFF_FFFF_FFFF_FFFF; vc[1] = 1'b0;
        va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h8000_0000_0000_0000; vs[2] = 64'h0;                   vc[2] = 1'b1;
        va[3] = 64'h0000_0000_FFFF_FFFF; vb[3] = 64'h1;                   vs[3] = 64'h0000_0001_0000_0000; vc[3] = 1'b0;
        va[4] = 64'h7FFF_FFFF_FFFF_FFFF; vb[4] = 64'h1;                   vs[4] = 64'h8000_0000_0000_0000; vc[4] = 1'b0;
        va[5] = 64'h1234_5678_9ABC_DEF0; vb[5] = 64'h1111_1111_1111_1111; vs[5] = 64'h2345_6789_ABCD_F001; vc[5] = 1'b0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready",  64'(b4.in_ready),  64'd0);
        chk("rst_out_valid", 64'(b4.out_valid), 64'd0);
        chk("rst_busy",      64'(b4.busy),      64'd0);
        chk("rst_cnt",       64'(b4.out_cnt),   64'd0);
        chk("rst_sum",       b4.out_sum,        64'd0);
        chk("rst_co",        64'(b4.out_co),    64'd0);

        // Contiguous 1,2,3,4
        b4.start = 1'b1; tick(); b4.start = 1'b0;
        chk("f1_in_ready", 64'(b4.in_ready), 64'd1);
        chk("f1_busy",     64'(b4.busy),     64'd1);
        feed4(1'b1, 64'd1);
        feed4(1'b1, 64'd2);
        feed4(1'b1, 64'd3);
        chk("f1_not_yet_valid", 64'(b4.out_valid), 64'd0);
        feed4(1'b1, 64'd4);
        b4.in_valid = 1'b0;
        chk("f1_out_valid", 64'(b4.out_valid), 64'd1);
        chk("f1_sum",       b4.out_sum,        64'd10);
        chk("f1_co",        64'(b4.out_co),    64'd0);
        chk("f1_cnt",       64'(b4.out_cnt),   64'd4);
        chk("f1_in_ready",  64'(b4.in_ready),  64'd0);

        // Result held under backpressure, start and terms ignored
        b4.start = 1'b1; b4.in_valid = 1'b1; b4.in_data = 64'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid",    64'(b4.out_valid), 64'd1);
            chk("hold_sum",      b4.out_sum,        64'd10);
            chk("hold_in_ready", 64'(b4.in_ready),  64'd0);
            chk("hold_cnt",      64'(b4.out_cnt),   64'd4);
        end
        b4.start = 1'b0; b4.in_valid = 1'b0; b4.out_ready = 1'b1;
        tick();
        b4.out_ready = 1'b0;
        chk("idle_valid",   64'(b4.out_valid), 64'd0);
        chk("idle_busy",    64'(b4.busy),      64'd0);
        chk("idle_sum_ret", b4.out_sum,        64'd10);
        chk("idle_cnt_ret", 64'(b4.out_cnt),   64'd4);

        // Gapped input, 5 each
        b4.start = 1'b1; tick(); b4.start = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            chk("gap_in_ready", 64'(b4.in_ready), 64'd1);
            feed4(pat[i], 64'd5);
            model_cnt += int'(pat[i]);
            chk("gap_cnt", 64'(b4.out_cnt), 64'(model_cnt));
        end
        b4.in_valid = 1'b0;
        chk("gap_valid", 64'(b4.out_valid), 64'd1);
        chk("gap_sum",   b4.out_sum,        64'd20);

        // Back-to-back into a wrapping frame with sticky carry
        b4.out_ready = 1'b1; b4.start = 1'b1; tick();
        b4.out_ready = 1'b0; b4.start = 1'b0;
        chk("b2b_in_ready", 64'(b4.in_ready), 64'd1);
        chk("b2b_cnt",      64'(b4.out_cnt),  64'd0);
        chk("b2b_sum",      b4.out_sum,       64'd0);
        feed4(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        feed4(1'b1, 64'd1);
        chk("wrap_sum0", b4.out_sum,     64'd0);
        chk("wrap_co",   64'(b4.out_co), 64'd1);
        feed4(1'b1, 64'd5);
        feed4(1'b1, 64'd6);
        b4.in_valid = 1'b0;
        chk("sticky_sum", b4.out_sum,     64'd11);
        chk("sticky_co",  64'(b4.out_co), 64'd1);

        b4.out_ready = 1'b1; b4.start = 1'b1; tick();
        b4.out_ready = 1'b0; b4.start = 1'b0;
        chk("b2b2_co",  64'(b4.out_co),  64'd0);
        chk("b2b2_cnt", 64'(b4.out_cnt), 64'd0);
        feed4(1'b1, 64'd10);
        feed4(1'b1, 64'd20);
        feed4(1'b1, 64'd30);
        feed4(1'b1, 64'd40);
        b4.in_valid = 1'b0;
        chk("b2b2_sum", b4.out_sum,     64'd100);
        chk("b2b2_co",  64'(b4.out_co), 64'd0);
        b4.out_ready = 1'b1; tick(); b4.out_ready = 1'b0;

        // Reset mid-frame wins over start/in_valid/out_ready
        b4.start = 1'b1; tick(); b4.start = 1'b0;
        feed4(1'b1, 64'd3);
        feed4(1'b1, 64'd3);
        rst = 1'b1; b4.start = 1'b1; b4.out_ready = 1'b1;
        feed4(1'b1, 64'd3);
        rst = 1'b0; b4.start = 1'b0; b4.out_ready = 1'b0; b4.in_valid = 1'b0;
        chk("mrst_in_ready", 64'(b4.in_ready),  64'd0);
        chk("mrst_valid",    64'(b4.out_valid), 64'd0);
        chk("mrst_cnt",      64'(b4.out_cnt),   64'd0);
        chk("mrst_sum",      b4.out_sum,        64'd0);
        tick();
        chk("mrst_no_valid", 64'(b4.out_valid), 64'd0);
        b4.start = 1'b1; tick(); b4.start = 1'b0;
        feed4(1'b1, 64'd7);
        b4.start = 1'b1;
        feed4(1'b1, 64'd7);
        b4.start = 1'b0;
        feed4(1'b1, 64'd7);
        feed4(1'b1, 64'd7);
        b4.in_valid = 1'b0;
        chk("f7_valid", 64'(b4.out_valid), 64'd1);
        chk("f7_sum",   b4.out_sum,        64'd28);
        chk("f7_cnt",   64'(b4.out_cnt),   64'd4);

        // LEN=2 carry-tree vectors
        for (int i = 0; i < 6; i++) begin
            b2.start = 1'b1; tick(); b2.start = 1'b0;
            b2.in_valid = 1'b1; b2.in_data = va[i]; tick();
            b2.in_data = vb[i]; tick();
            b2.in_valid = 1'b0;
            chk("l2_valid", 64'(b2.out_valid), 64'd1);
            chk("l2_sum",   b2.out_sum,        vs[i]);
            chk("l2_co",    64'(b2.out_co),    64'(vc[i]));
            chk("l2_cnt",   64'(b2.out_cnt),   64'd2);
            b2.out_ready = 1'b1; tick(); b2.out_ready = 1'b0;
        end

        // LEN=1: single term completes the frame
        b1.start = 1'b1; tick(); b1.start = 1'b0;
        b1.in_valid = 1'b1; b1.in_data = 64'hDEAD_BEEF_CAFE_F00D; tick();
        b1.in_valid = 1'b0;
        chk("l1_valid", 64'(b1.out_valid), 64'd1);
        chk("l1_sum",   b1.out_sum,        64'hDEAD_BEEF_CAFE_F00D);
        chk("l1_co",    64'(b1.out_co),    64'd0);
        chk("l1_cnt",   64'(b1.out_cnt),   64'd1);
        b1.out_ready = 1'b1; b1.start = 1'b1; tick(); b1.start = 1'b0; b1.out_ready = 1'b0;
        b1.in_valid = 1'b1; b1.in_data = 64'hFFFF_FFFF_FFFF_FFFF; tick();
        b1.in_valid = 1'b0;
        chk("l1_sum_max", b1.out_sum,     64'hFFFF_FFFF_FFFF_FFFF);
        chk("l1_co_max",  64'(b1.out_co), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adder_acc64.md
ADDER_ACC64 -- requirements
Module: adder_acc64

Interface
REQ-001 Parameter: LEN, default 8, number of 64-bit terms summed per frame, legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to open a new accumulation frame.
REQ-005 in_valid  input  1  in_data carries a term.
REQ-006 in_ready  output  1  block accepts a term this cycle.
REQ-007 in_data  input  64  unsigned term.
REQ-008 out_valid  output  1  frame result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_sum  output  64  frame sum modulo 2^64.
REQ-011 out_co  output  1  sticky carry: set if any addition in the frame produced carry-out.
REQ-012 out_cnt  output  8  number of terms accepted in the current or last frame.
REQ-013 busy  output  1  high in ACCUM and DONE.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM, DONE.
REQ-015 IDLE: in_ready=0, out_valid=0; start -> ACCUM, clearing accumulator, out_cnt and sticky carry to 0 in the same edge.
REQ-016 ACCUM: in_ready=1; a term is accepted when in_valid && in_ready.
REQ-017 On acceptance, the accumulator SHALL load the combinational sum (accumulator + in_data), sticky carry SHALL OR in the adder carry-out, out_cnt SHALL increment.
REQ-018 Cycles with in_valid=0 in ACCUM SHALL leave all state unchanged (gaps allowed, unlimited).
REQ-019 Accepting the LEN-th term SHALL move to DONE; out_valid SHALL assert the next cycle (latency: 1 cycle from last accept).
REQ-020 DONE: out_valid=1, in_ready=0; out_sum, out_co, out_cnt SHALL be stable until out_valid && out_ready.
REQ-021 DONE with out_ready=1 and start=0 -> IDLE; outputs retain last values.
REQ-022 DONE with out_ready=1 and start=1 -> ACCUM with cleared state (back-to-back frames, no idle cycle).
REQ-023 start SHALL be ignored in ACCUM and in DONE when out_ready=0.
REQ-024 Accumulator wraps modulo 2^64; wrap is reported only via out_co.
REQ-025 out_sum SHALL be driven directly from the accumulator register (no combinational path from in_data to outputs).
REQ-026 LEN=1: one accepted term -> DONE, out_sum = that term, out_co=0.

Reset
REQ-027 rst SHALL force IDLE, accumulator=0, out_co=0, out_cnt=0, out_valid=0, in_ready=0, busy=0 on the next edge.
REQ-028 rst asserted mid-frame SHALL discard the partial sum; no out_valid is produced for that frame.
REQ-029 rst SHALL take priority over start, in_valid and out_ready in the same cycle.

Structure
REQ-030 Shared package adder_pkg SHALL hold the data-width constant (64) and the FSM state enum.
REQ-031 Exactly one sub-module: one sparse_adder64 instance with A=accumulator, B=in_data; its SUM and CO feed the accumulator and sticky-carry registers.
REQ-032 No other arithmetic on the 64-bit datapath; the counter is a separate 8-bit increment.

Verification
REQ-033 LEN=4, start, terms 1,2,3,4 contiguous -> out_valid one cycle after 4th accept, out_sum=10, out_co=0, out_cnt=4.
REQ-034 LEN=2, terms 0xFFFF_FFFF_FFFF_FFFF, 0x2 -> out_sum=0x1, out_co=1.
REQ-035 LEN=4, in_valid toggled 1,0,0,1,0,1,1 with terms 5 each -> out_sum=20, out_cnt=4, in_ready high throughout ACCUM.
REQ-036 Result pending, out_ready=0 for 5 cycles -> out_valid held, out_sum unchanged, in_ready=0, start ignored.
REQ-037 LEN=4, rst after 2 accepted terms -> next cycle in_ready=0, out_valid=0, out_cnt=0; new frame 7,7,7,7 -> out_sum=28.
REQ-038 DONE with out_ready=1 and start=1 -> next cycle ACCUM, in_ready=1, out_cnt=0, out_co=0; second frame sums independently.
